// File: rtl/shift_add_multiplier_4bit_pkg.sv
// Shared constants for the shift-and-add multiplier: widths, iteration
// count, FSM encodings and the partial-product gating helper.
package shift_add_multiplier_4bit_pkg;

   localparam int MUL_W  = 4;
   localparam int PROD_W = 8;
   localparam int ITER_N = 4;
   localparam int CNT_W  = 2;

   // Counter value of the final iteration (ITER_N - 1).
   localparam logic [CNT_W-1:0] LAST_CNT = 2'd3;

   // FSM encodings; the unused code 2'b11 falls back to IDLE.
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_CALC = 2'b01;
   localparam logic [1:0] ST_FIN  = 2'b10;

   // Partial product for one iteration: the multiplicand when the current
   // multiplier bit is set, otherwise zero.
   function automatic logic [MUL_W-1:0] gate_operand(input logic [MUL_W-1:0] m,
                                                     input logic             en);
      logic [MUL_W-1:0] r;
      if (en) begin
         r = m;
      end else begin
         r = 4'b0000;
      end
      return r;
   endfunction

endpackage

// File: rtl/ripple_carry_adder_4bit.sv
// 4-bit ripple-carry adder: S = A + B + CI, carry out on CO.
module ripple_carry_adder_4bit (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       CI,
   output logic [3:0] S,
   output logic       CO
);

   logic [4:0] c_s;

   assign c_s[0] = CI;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign S[i]     = A[i] ^ B[i] ^ c_s[i];
      assign c_s[i+1] = (A[i] & B[i]) | (c_s[i] & (A[i] ^ B[i]));
   end

   assign CO = c_s[4];

endmodule

// File: rtl/shift_add_multiplier_4bit.sv
// Sequential 4x4 unsigned shift-and-add multiplier. One iteration per
// clock through the shared ripple-carry adder; START/DONE handshake.
module shift_add_multiplier_4bit
   import shift_add_multiplier_4bit_pkg::*;
(
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   input  logic [MUL_W-1:0]  A,
   input  logic [MUL_W-1:0]  B,
   output logic              BUSY,
   output logic              DONE,
   output logic [PROD_W-1:0] P
);

   logic [1:0]        state_q, state_d;
   logic [MUL_W-1:0]  acc_q,   acc_d;
   logic [MUL_W-1:0]  q_q,     q_d;
   logic [MUL_W-1:0]  m_q,     m_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [PROD_W-1:0] p_q,     p_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;

   logic [MUL_W-1:0]  addend_s;
   logic [MUL_W-1:0]  sum_s;
   logic              co_s;

   assign addend_s = gate_operand(m_q, q_q[0]);

   // ACC + M never exceeds 30, so {CO,S} always holds the exact sum.
   ripple_carry_adder_4bit u_adder (
      .A  (acc_q),
      .B  (addend_s),
      .CI (1'b0),
      .S  (sum_s),
      .CO (co_s)
   );

   // Next-state, datapath and output decode for the IDLE/CALC/FIN sequence.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      q_d     = q_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               m_d     = A;
               q_d     = B;
               acc_d   = 4'b0000;
               cnt_d   = 2'd0;
               state_d = ST_CALC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            acc_d = {co_s, sum_s[3:1]};
            q_d   = {sum_s[0], q_q[3:1]};
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == LAST_CNT) begin
               p_d     = {co_s, sum_s[3:1], sum_s[0], q_q[3:1]};
               state_d = ST_FIN;
            end else begin
               state_d = ST_CALC;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // Flags are registered from the next state so they align with it.
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_FIN);
   end

   // State, datapath and output registers; reset aborts any multiply.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         acc_q   <= 4'b0000;
         q_q     <= 4'b0000;
         m_q     <= 4'b0000;
         cnt_q   <= 2'd0;
         p_q     <= 8'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign P    = p_q;

endmodule

// File: tb/tb_shift_add_multiplier_4bit.sv
// Directed self-checking bench for shift_add_multiplier_4bit.
module tb_shift_add_multiplier_4bit;

   logic       CLK;
   logic       RST_N;
   logic       START;
   logic [3:0] A;
   logic [3:0] B;
   logic       BUSY;
   logic       DONE;
   logic [7:0] P;

   int checks;
   int failures;
   int done_cnt;
   int done_base;

   shift_add_multiplier_4bit dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .START (START),
      .A     (A),
      .B     (B),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .P     (P)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Count clock edges on which DONE was high.
   initial done_cnt = 0;
   always @(posedge CLK) begin
      if (DONE === 1'b1) done_cnt <= done_cnt + 1;
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Accept a, b on the next edge and check the whole 6-cycle transaction.
   task automatic run_mul(input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp_p, input string tag);
      int base;
      base  = done_cnt;
      A     = a;
      B     = b;
      START = 1'b1;
      tick();                       // t0
      START = 1'b0;
      A     = ~a;                   // must not affect the running multiply
      B     = ~b;
      chk({tag, "_busy_t0"}, BUSY, 1);
      chk({tag, "_done_t0"}, DONE, 0);
      tick(); tick(); tick();       // t0+3
      chk({tag, "_busy_t3"}, BUSY, 1);
      chk({tag, "_done_t3"}, DONE, 0);
      tick();                       // t0+4
      chk({tag, "_done_t4"}, DONE, 1);
      chk({tag, "_busy_t4"}, BUSY, 1);
      chk({tag, "_p_t4"},    P,    exp_p);
      tick();                       // t0+5
      chk({tag, "_done_t5"}, DONE, 0);
      chk({tag, "_busy_t5"}, BUSY, 0);
      chk({tag, "_p_t5"},    P,    exp_p);
      chk({tag, "_pulses"},  done_cnt - base, 1);
      tick();
      chk({tag, "_p_held"},  P,    exp_p);
      chk({tag, "_idle"},    BUSY, 0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      RST_N    = 1'b0;
      START    = 1'b1;
      A        = 4'd3;
      B        = 4'd5;

      // Reset held with START high: outputs stay at reset values.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_p",    P,    8'h00);
         chk("rst_done", DONE, 0);
         chk("rst_busy", BUSY, 0);
      end
      RST_N = 1'b1;

      // First post-reset edge accepts.
      run_mul(4'd3,  4'd5, 8'h0F, "m3x5");
      run_mul(4'hF,  4'hF, 8'hE1, "mFxF");
      run_mul(4'd0,  4'd9, 8'h00, "m0x9");
      run_mul(4'd9,  4'd0, 8'h00, "m9x0");
      run_mul(4'd13, 4'd11, 8'h8F, "m13x11");

      // Back-to-back with START held high.
      done_base = done_cnt;
      A     = 4'd7;
      B     = 4'd6;
      START = 1'b1;
      tick();                       // t0
      A = 4'd2;
      B = 4'd2;
      tick(); tick(); tick(); tick(); // t0+4
      chk("b2b_done1", DONE, 1);
      chk("b2b_p1",    P,    8'h2A);
      tick();                       // t0+5
      chk("b2b_busy5", BUSY, 0);
      chk("b2b_done5", DONE, 0);
      tick();                       // t0+6: second accept
      chk("b2b_busy6", BUSY, 1);
      chk("b2b_p6",    P,    8'h2A);
      START = 1'b0;
      tick(); tick(); tick(); tick(); // t0+10
      chk("b2b_done2", DONE, 1);
      chk("b2b_p2",    P,    8'h04);
      tick();                       // t0+11
      chk("b2b_busy11", BUSY, 0);
      chk("b2b_pulses", done_cnt - done_base, 2);

      // Reset in the middle of a multiply.
      done_base = done_cnt;
      A     = 4'd5;
      B     = 4'd5;
      START = 1'b1;
      tick();                       // t0
      START = 1'b0;
      tick(); tick();               // second iteration edge
      chk("mid_busy_pre", BUSY, 1);
      RST_N = 1'b0;
      #1;
      chk("mid_busy_async", BUSY, 0);
      chk("mid_p_async",    P,    8'h00);
      chk("mid_done_async", DONE, 0);
      tick(); tick(); tick();
      chk("mid_busy_hold",  BUSY, 0);
      chk("mid_p_hold",     P,    8'h00);
      chk("mid_no_done",    done_cnt - done_base, 0);
      RST_N = 1'b1;
      run_mul(4'd2, 4'd4, 8'h08, "m2x4");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
